// File: rtl/inc_pkg.sv
// Shared types and helpers for the bit-serial incrementer.
// No logic; state encoding plus counter-width helper.
// Imported by the incrementer top level.
package inc_pkg;

    // FSM state encoding: kept as plain logic constants so legacy flows can read it
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bit counter must hold the value WIDTH itself, so size it for WIDTH+1 codes
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_incrementer_if.sv
// Word-level valid/ready bus around the bit-serial incrementer.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready carry flow control in each direction.
interface serial_incrementer_if #(
    parameter int WIDTH = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             busy;

    // Upstream loader / downstream consumer side
    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out, wrap, busy
    );

    // Incrementer side
    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out, wrap, busy
    );
endinterface

// File: rtl/serial_half_add.sv
// One-bit half adder used for the serial carry chain.
// Latency: combinational.
// Backpressure: none.
module serial_half_add (
    input  logic i_a,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_cin;
    assign o_cout = i_a & i_cin;
endmodule

// File: rtl/serial_incrementer.sv
// Bit-serial (in + 1) mod 2^WIDTH, LSB first, one bit per cycle; wrap flags an all-ones operand.
// Latency: result valid WIDTH cycles after the accept; one word per WIDTH + 2 cycles.
// Backpressure: result and wrap hold in DONE until out_ready; in_ready only in IDLE.
module serial_incrementer
    import inc_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_incrementer_if.slave  bus
);
    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_out;
    logic             r_wrap;

    logic [WIDTH-1:0] w_sh_next;
    logic             w_s;
    logic             w_cout;
    logic             w_accept;
    logic             w_last;

    assign w_accept = bus.in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_state == ST_BUSY) && (r_cnt == LAST);

    serial_half_add u_half_add (
        .i_a    (r_sh[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // Sum bit enters at the MSB; a 1-bit word has nothing to shift down
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_sh_next = w_s;
        end else begin : g_wn
            assign w_sh_next = {w_s, r_sh[WIDTH-1:1]};
        end
    endgenerate

    // FSM: IDLE -> BUSY on accept, BUSY -> DONE after the last step, DONE -> IDLE on out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept)      r_state <= ST_BUSY;
                ST_BUSY: if (w_last)        r_state <= ST_DONE;
                ST_DONE: if (bus.out_ready) r_state <= ST_IDLE;
                default:                    r_state <= ST_IDLE;
            endcase
        end
    end

    // Serial datapath: load operand with carry-in 1, then one half-add step per BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh    <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_sh    <= bus.in;
            r_carry <= 1'b1;
            r_cnt   <= '0;
        end else if (r_state == ST_BUSY) begin
            r_sh    <= w_sh_next;
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Result registers capture on the final step and hold through any DONE stall
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= '0;
            r_wrap <= 1'b0;
        end else if (w_last) begin
            r_out  <= w_sh_next;
            r_wrap <= w_cout;
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.out       = r_out;
    assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_serial_incrementer.sv
// Scoreboard bench for serial_incrementer at WIDTH 2, 8 and 1.
// Drivers push hand-computed results into per-instance queues; monitors pop on out_valid & out_ready.
// Covers reset, all 2-bit words, backpressure, mid-operation reset, WIDTH=8 streaming, WIDTH=1.
module tb_serial_incrementer;

    typedef struct {
        logic [7:0] res;
        logic       wrap;
        logic [7:0] orig;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q2[$];
    exp_t q8[$];
    exp_t q1[$];
    int   acc8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_incrementer_if #(.WIDTH(2)) b2 ();
    serial_incrementer_if #(.WIDTH(8)) b8 ();
    serial_incrementer_if #(.WIDTH(1)) b1 ();

    serial_incrementer #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    serial_incrementer #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
    serial_incrementer #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // Hand-computed vectors: {operand, result, wrap}
    logic [1:0] v2_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] v2_out [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic       v2_wrap[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] v8_in  [3] = '{8'hFF, 8'h7F, 8'h00};
    logic [7:0] v8_out [3] = '{8'h00, 8'h80, 8'h01};
    logic       v8_wrap[3] = '{1'b1, 1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // ---------------- monitors (sample 1 unit after negedge) ----------------
    logic       pv2 = 1'b0, pv8 = 1'b0, pv1 = 1'b0;
    exp_t       e2, e8, e1;
    logic [1:0] rt2;
    logic [7:0] rt8;
    logic       rt1;

    always begin
        @(negedge clk); #1;
        if (b2.out_valid && !pv2) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL w2_unexpected: out_valid with out=%0h, required no result", b2.out);
            end else check("w2_latency", cyc - q2[0].acc, 2);
        end
        if (b2.out_valid && b2.out_ready && q2.size() != 0) begin
            e2  = q2.pop_front();
            rt2 = b2.out - 2'd1;
            check("w2_out", b2.out, e2.res);
            check("w2_wrap", b2.wrap, e2.wrap);
            check("w2_roundtrip", rt2, e2.orig);
        end
        pv2 = b2.out_valid;
    end

    always begin
        @(negedge clk); #1;
        if (b8.out_valid && !pv8) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL w8_unexpected: out_valid with out=%0h, required no result", b8.out);
            end else check("w8_latency", cyc - q8[0].acc, 8);
        end
        if (b8.out_valid && b8.out_ready && q8.size() != 0) begin
            e8  = q8.pop_front();
            rt8 = b8.out - 8'd1;
            check("w8_out", b8.out, e8.res);
            check("w8_wrap", b8.wrap, e8.wrap);
            check("w8_roundtrip", rt8, e8.orig);
        end
        pv8 = b8.out_valid;
    end

    always begin
        @(negedge clk); #1;
        if (b1.out_valid && !pv1) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL w1_unexpected: out_valid with out=%0h, required no result", b1.out);
            end else check("w1_latency", cyc - q1[0].acc, 1);
        end
        if (b1.out_valid && b1.out_ready && q1.size() != 0) begin
            e1  = q1.pop_front();
            rt1 = b1.out - 1'b1;
            check("w1_out", b1.out, e1.res);
            check("w1_wrap", b1.wrap, e1.wrap);
            check("w1_roundtrip", rt1, e1.orig);
        end
        pv1 = b1.out_valid;
    end

    // ---------------- drivers (called at a negedge) ----------------
    task automatic send2(input logic [1:0] d, input logic [1:0] r, input logic w);
        int   n = 0;
        exp_t e;
        b2.in = d; b2.in_valid = 1'b1;
        while (!b2.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!b2.in_ready) expire("w2_accept");
        else begin
            e.res = 8'(r); e.wrap = w; e.orig = 8'(d); e.acc = cyc + 1;
            q2.push_back(e);
        end
        @(negedge clk);
        b2.in_valid = 1'b0;
    endtask

    task automatic send1(input logic d, input logic r, input logic w);
        int   n = 0;
        exp_t e;
        b1.in = d; b1.in_valid = 1'b1;
        while (!b1.in_ready && n < 50) begin @(negedge clk); n++; end
        if (!b1.in_ready) expire("w1_accept");
        else begin
            e.res = 8'(r); e.wrap = w; e.orig = 8'(d); e.acc = cyc + 1;
            q1.push_back(e);
        end
        @(negedge clk);
        b1.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q2.size() + q8.size() + q1.size()) != 0 && n < 100) begin
            @(negedge clk); n++;
        end
        if ((q2.size() + q8.size() + q1.size()) != 0) expire("drain");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b2.in_valid = 1'b0; b2.in = '0; b2.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.in = '0; b8.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in = '0; b1.out_ready = 1'b1;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", b2.in_ready, 1);
        check("rst_out_valid", b2.out_valid, 0);
        check("rst_out", b2.out, 0);
        check("rst_wrap", b2.wrap, 0);
        check("rst_busy", b2.busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", b2.in_ready, 1);
        check("post_rst_w8_in_ready", b8.in_ready, 1);

        // All 2-bit operands
        for (int i = 0; i < 4; i++) send2(v2_in[i], v2_out[i], v2_wrap[i]);
        drain();

        // WIDTH = 1 boundary
        send1(1'b0, 1'b1, 1'b0);
        send1(1'b1, 1'b0, 1'b1);
        drain();

        // Backpressure: result must hold while out_ready is low
        b2.out_ready = 1'b0;
        send2(2'b01, 2'b10, 1'b0);
        begin
            int n = 0;
            while (!b2.out_valid && n < 20) begin @(negedge clk); n++; end
            if (!b2.out_valid) expire("bp_out_valid");
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", b2.out_valid, 1);
            check("bp_out", b2.out, 2'b10);
            check("bp_in_ready", b2.in_ready, 0);
            b2.in = 2'b11; b2.in_valid = 1'b1;
            @(negedge clk);
        end
        b2.in_valid = 1'b0;
        b2.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", b2.out_valid, 0);
        check("bp_release_in_ready", b2.in_ready, 1);
        check("bp_one_transfer", q2.size(), 0);

        // Reset during the first BUSY edge discards the operation
        b2.in = 2'b11; b2.in_valid = 1'b1;
        check("mid_rst_accept_ready", b2.in_ready, 1);
        @(negedge clk);
        b2.in_valid = 1'b0;
        check("mid_rst_busy", b2.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready", b2.in_ready, 1);
        check("mid_rst_out_valid", b2.out_valid, 0);
        check("mid_rst_out", b2.out, 0);
        check("mid_rst_wrap", b2.wrap, 0);
        check("mid_rst_busy_low", b2.busy, 0);
        repeat (6) @(negedge clk);

        // WIDTH = 8 back-to-back stream with in_valid held high
        b8.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int   n = 0;
            exp_t e;
            b8.in = v8_in[i];
            while (!b8.in_ready && n < 50) begin @(negedge clk); n++; end
            if (!b8.in_ready) expire("w8_accept");
            else begin
                e.res = v8_out[i]; e.wrap = v8_wrap[i]; e.orig = v8_in[i]; e.acc = cyc + 1;
                q8.push_back(e);
                acc8.push_back(cyc + 1);
            end
            @(negedge clk);
        end
        b8.in_valid = 1'b0;
        drain();
        if (acc8.size() == 3) begin
            check("w8_spacing_0", acc8[1] - acc8[0], 10);
            check("w8_spacing_1", acc8[2] - acc8[1], 10);
        end else expire("w8_spacing");

        repeat (3) @(negedge clk);
        check("end_q2_empty", q2.size(), 0);
        check("end_q8_empty", q8.size(), 0);
        check("end_q1_empty", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
